// File: rtl/nn_parameters.sv
// Shared network dimensions and element types for the feature front-end.
// IN_SIZE_1 is the single source for the length of an input feature frame.
package nn_parameters;

  localparam int IN_SIZE_1   = 4;
  localparam int FRAME_CNT_W = $clog2(IN_SIZE_1);

  typedef logic signed [7:0] feature_t;

  // Element counter width for an arbitrary frame length; never narrower than 1 bit.
  function automatic int cnt_width(input int vec_len);
    return (vec_len < 2) ? 1 : $clog2(vec_len);
  endfunction

endpackage

// File: rtl/feature_frame_buffer_bank.sv
// feature_bank: one frame of storage. Indexed single-element write,
// whole-bank synchronous clear, and a parallel read of every element.
// Clear wins over a write in the same cycle, so a bank that is being
// discarded can never keep a stray element.
module feature_bank
  import nn_parameters::*;
#(
  parameter int VEC_LEN = IN_SIZE_1,
  parameter int DATA_W  = 8,
  parameter int IDX_W   = cnt_width(VEC_LEN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     clr,
  output logic signed [DATA_W-1:0] rd_data [0:VEC_LEN-1]
);

  logic signed [DATA_W-1:0] mem_q [0:VEC_LEN-1];
  logic signed [DATA_W-1:0] mem_d [0:VEC_LEN-1];

  // Next bank contents: clear, else write one element, else hold.
  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      for (int i = 0; i < VEC_LEN; i++) begin
        mem_d[i] = '0;
      end
    end else if (wr_en) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  // Storage registers with synchronous active-low reset to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < VEC_LEN; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q;

endmodule

// File: rtl/feature_frame_buffer.sv
// feature_frame_buffer: packs a serial stream of signed feature elements
// into VEC_LEN-element frames held in a ping-pong pair of banks and offers
// each completed frame as a parallel vector with a valid/ready handshake.
// Optional: FEATURE_FRAME_BUF_FLUSH_EN adds a flush input that discards
// the partial frame currently being collected.
module feature_frame_buffer
  import nn_parameters::*;
#(
  parameter int VEC_LEN = IN_SIZE_1,
  parameter int DATA_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef FEATURE_FRAME_BUF_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DATA_W-1:0] m_vector [0:VEC_LEN-1],
  output logic                     frame_err
);

  localparam int CNT_W = cnt_width(VEC_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       full_q, full_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_err_q, frame_err_d;

  logic             flush_w;
  logic             accept_w;
  logic             at_last_w;
  logic             complete_w;
  logic             rel_w;
  logic [1:0]       bank_wr_en;
  logic [1:0]       bank_clr;

  logic signed [DATA_W-1:0] bank0_rd [0:VEC_LEN-1];
  logic signed [DATA_W-1:0] bank1_rd [0:VEC_LEN-1];

`ifdef FEATURE_FRAME_BUF_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Handshake outputs come straight from registered flags and pointers.
  assign s_ready   = !full_q[wr_ptr_q];
  assign m_valid   = full_q[rd_ptr_q];
  assign frame_err = frame_err_q;

  // Next-state for pointers, full flags, element counter and error pulse.
  // Completion targets the write bank and release the read bank; a full
  // bank cannot be written, so the two never collide on one bank.
  always_comb begin
    accept_w    = s_valid && s_ready;
    at_last_w   = (cnt_q == LAST_IDX);
    complete_w  = accept_w && !flush_w && (s_last || at_last_w);
    rel_w       = full_q[rd_ptr_q] && m_ready;

    full_d      = full_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    frame_err_d = 1'b0;

    if (rel_w) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = !rd_ptr_q;
    end

    if (flush_w) begin
      cnt_d = '0;
    end else if (complete_w) begin
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = !wr_ptr_q;
      cnt_d            = '0;
      // Early s_last or a missing s_last on the final slot: exactly one is true.
      frame_err_d      = s_last ^ at_last_w;
    end else if (accept_w) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Bank write enables and clears; a flushed beat never lands in storage.
  always_comb begin
    bank_wr_en[0] = accept_w && !flush_w && !wr_ptr_q;
    bank_wr_en[1] = accept_w && !flush_w &&  wr_ptr_q;
    bank_clr[0]   = (rel_w && !rd_ptr_q) || (flush_w && !wr_ptr_q);
    bank_clr[1]   = (rel_w &&  rd_ptr_q) || (flush_w &&  wr_ptr_q);
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      full_q      <= 2'b00;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      full_q      <= full_d;
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  feature_bank #(
    .VEC_LEN (VEC_LEN),
    .DATA_W  (DATA_W),
    .IDX_W   (CNT_W)
  ) u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bank_wr_en[0]),
    .wr_idx  (cnt_q),
    .wr_data (s_data),
    .clr     (bank_clr[0]),
    .rd_data (bank0_rd)
  );

  feature_bank #(
    .VEC_LEN (VEC_LEN),
    .DATA_W  (DATA_W),
    .IDX_W   (CNT_W)
  ) u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bank_wr_en[1]),
    .wr_idx  (cnt_q),
    .wr_data (s_data),
    .clr     (bank_clr[1]),
    .rd_data (bank1_rd)
  );

  // Present the bank the read pointer selects.
  always_comb begin
    for (int i = 0; i < VEC_LEN; i++) begin
      m_vector[i] = rd_ptr_q ? bank1_rd[i] : bank0_rd[i];
    end
  end

endmodule

// File: tb/tb_feature_frame_buffer.sv
// Bench for feature_frame_buffer (VEC_LEN=4). A frame-level reference model
// (a queue of completed frames plus one partial frame) predicts every output.
module tb_feature_frame_buffer;

  localparam int VL = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 s_valid, s_ready, s_last;
  logic signed [DW-1:0] s_data;
  logic                 m_valid, m_ready, frame_err;
  logic signed [DW-1:0] m_vector [0:VL-1];
`ifdef FEATURE_FRAME_BUF_FLUSH_EN
  logic                 flush;
`endif

  feature_frame_buffer #(.VEC_LEN(VL), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef FEATURE_FRAME_BUF_FLUSH_EN
    .flush     (flush),
`endif
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_vector  (m_vector),
    .frame_err (frame_err)
  );

  typedef int frame_t [VL];

  frame_t fq[$];
  frame_t part;
  int     pcnt;
  int     exp_err;
  int     n_vec;
  int     n_bad;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_clear();
    fq.delete();
    for (int i = 0; i < VL; i++) part[i] = 0;
    pcnt    = 0;
    exp_err = 0;
  endfunction

  // Frame-level update for one clock edge given the inputs driven for it.
  function automatic void model_edge(input logic sv, input int sd, input logic sl,
                                     input logic mr, input logic fl);
    bit acc, rel;
    acc     = sv && (fq.size() < 2);
    rel     = (fq.size() > 0) && mr;
    exp_err = 0;
    if (rel) void'(fq.pop_front());
    if (fl) begin
      for (int i = 0; i < VL; i++) part[i] = 0;
      pcnt = 0;
    end else if (acc) begin
      part[pcnt] = sd;
      if (sl || pcnt == VL - 1) begin
        exp_err = (sl != (pcnt == VL - 1)) ? 1 : 0;
        fq.push_back(part);
        for (int i = 0; i < VL; i++) part[i] = 0;
        pcnt = 0;
      end else begin
        pcnt++;
      end
    end
  endfunction

  task automatic check_outputs();
    chk("s_ready", int'(s_ready), (fq.size() < 2) ? 1 : 0);
    chk("m_valid", int'(m_valid), (fq.size() > 0) ? 1 : 0);
    chk("frame_err", int'(frame_err), exp_err);
    if (fq.size() > 0) begin
      for (int i = 0; i < VL; i++) chk($sformatf("m_vector[%0d]", i), int'(m_vector[i]), fq[0][i]);
    end
  endtask

  task automatic step(input logic sv, input int sd, input logic sl,
                      input logic mr, input logic fl);
    @(negedge clk);
    check_outputs();
    s_valid = sv;
    s_data  = DW'(sd);
    s_last  = sl;
    m_ready = mr;
`ifdef FEATURE_FRAME_BUF_FLUSH_EN
    flush   = fl;
`endif
    @(posedge clk);
`ifdef FEATURE_FRAME_BUF_FLUSH_EN
    model_edge(sv, sd, sl, mr, fl);
`else
    model_edge(sv, sd, sl, mr, 1'b0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
`ifdef FEATURE_FRAME_BUF_FLUSH_EN
    flush   = 1'b0;
`endif
    @(posedge clk);
    model_clear();
    @(negedge clk);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_s_ready", int'(s_ready), 1);
    for (int i = 0; i < VL; i++) chk($sformatf("rst_m_vector[%0d]", i), int'(m_vector[i]), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    model_clear();
    rst_n = 1'b0;
    do_reset();

    // Frame 1..4 with s_last on the fourth beat, consumer stalled.
    for (int i = 1; i <= 4; i++) step(1'b1, i, i == 4, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    // Second frame fills the other bank; a ninth beat is then refused.
    for (int i = 5; i <= 8; i++) step(1'b1, i, i == 8, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 9, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Early s_last: {-3,7,0,0} with one error pulse.
    step(1'b1, -3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 7, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    // Missing s_last: {9,10,11,12} still completes, error pulses.
    for (int i = 9; i <= 12; i++) step(1'b1, i, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Sustained streaming, consumer always ready.
    for (int i = 0; i < 12; i++) step(1'b1, 20 + i, (i % 4) == 3, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);

    // Reset mid-frame, then a clean frame with no residue.
    step(1'b1, 55, 1'b0, 1'b0, 1'b0);
    step(1'b1, 66, 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, i, i == 4, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);

`ifdef FEATURE_FRAME_BUF_FLUSH_EN
    // Flush mid-frame, including a beat offered in the flush cycle.
    step(1'b1, 77, 1'b0, 1'b0, 1'b0);
    step(1'b1, 88, 1'b0, 1'b0, 1'b0);
    step(1'b1, 99, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) step(1'b1, i, i == 4, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      step(($urandom % 4) != 0, int'($urandom_range(0, 255)) - 128,
           ($urandom % 5) == 0, ($urandom % 2) == 0,
`ifdef FEATURE_FRAME_BUF_FLUSH_EN
           ($urandom % 25) == 0
`else
           1'b0
`endif
      );
    end
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/feature_frame_buffer.md
Name: feature_frame_buffer

Overview:
- Upstream neighbour of the first dense layer. Collects a serial stream of signed 8-bit feature values into full frames of VEC_LEN elements.
- Uses a ping-pong (double) buffer so the producer keeps streaming while the consumer holds a frame.
- Presents each completed frame as a parallel vector with a valid/ready handshake.
- The dense layer reads m_vector combinationally while m_valid is high.

Parameters:
- VEC_LEN, default IN_SIZE_1 (from nn_parameters): elements per frame; must be >= 2.
- DATA_W, default 8: element width, signed two's complement.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- s_valid  in  1  producer offers s_data.
- s_ready  out  1  buffer can accept a beat.
- s_data  in  DATA_W  signed feature element.
- s_last  in  1  producer marks the final element of its frame.
- m_valid  out  1  a complete frame is on m_vector.
- m_ready  in  1  consumer has taken the frame.
- m_vector  out  VEC_LEN x DATA_W  unpacked array [0:VEC_LEN-1]; element 0 is the first beat of the frame.
- frame_err  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Both banks cleared to 0; both full flags cleared; write/read bank pointers set to bank 0; element counter set to 0.
  - Outputs: m_valid=0, frame_err=0, m_vector all zero. s_ready=1 from the first cycle after reset.
  - Reset mid-frame discards the partial frame and any full frames.
- Accept rule: a beat is accepted when s_valid && s_ready. s_ready = !full[wr_ptr], derived from registered state only.
- Storage: an accepted beat writes s_data to bank[wr_ptr][cnt] and increments cnt.
- Frame completion: the frame completes on the accepted beat where cnt == VEC_LEN-1, or where s_last=1 (whichever comes first). On the next edge:
  - full[wr_ptr] is set, wr_ptr toggles, cnt returns to 0.
- Early s_last (cnt < VEC_LEN-1):
  - Unwritten elements remain 0, because banks are zero on release.
  - frame_err pulses in the cycle after the completing beat.
- Missing s_last: if the beat at cnt == VEC_LEN-1 has s_last=0, the frame still completes and frame_err pulses.
- Output side:
  - m_valid = full[rd_ptr]; m_vector = bank[rd_ptr].
  - While m_valid is high, m_vector is held stable until the handshake.
- Release: on m_valid && m_ready, on the next edge:
  - full[rd_ptr] cleared, bank[rd_ptr] zeroed, rd_ptr toggles.
- Latency: last beat accepted at cycle N -> m_valid=1 at cycle N+1.
- Throughput: with m_ready tied high, streaming is sustained at one beat per cycle with no s_ready gaps.
- Both banks full: s_ready=0. After a release at edge E, s_ready=1 in the cycle following E.
- Simultaneous events:
  - A release and a frame completion in the same cycle on different banks are both honoured.
  - Completion and release can never target the same bank.
- frame_err and completion are registered; frame_err is never held for more than one cycle.

Optional Feature:
- Macro: FEATURE_FRAME_BUF_FLUSH_EN.
- With the macro defined:
  - Adds input port flush (1 bit). A high flush at an edge discards the partial frame in bank[wr_ptr]: cnt=0 and that bank is zeroed.
  - A beat accepted in the same cycle as flush is discarded.
  - Full banks, rd_ptr and m_valid are unaffected.
  - flush takes priority over frame completion.
- Without the macro: no flush port; partial frames are discarded only by reset.

Decomposition:
- nn_parameters package gains:
  - FRAME_CNT_W = $clog2(VEC_LEN) constant.
  - typedef feature_t = logic signed [7:0].
  - IN_SIZE_1 stays the single source for frame length.
- One natural sub-module, feature_bank: one VEC_LEN-entry register array with indexed write, synchronous clear, and parallel read. It is instantiated twice; the parent holds the pointers, counter, flags and error logic.

Test Plan (VEC_LEN=4):
- Reset, then stream 1,2,3,4 with s_last on 4 and m_ready=0 -> m_valid=1 one cycle after beat 4; m_vector={1,2,3,4}; frame_err=0; s_ready stays 1.
- With m_ready=0, send a second frame 5..8 -> second bank fills. Then send a ninth beat -> s_ready=0 after 8 is accepted; m_vector still {1,2,3,4}. Pulse m_ready -> m_vector={5,6,7,8} next cycle and s_ready=1.
- Send -3,7 with s_last on 7 -> frame {-3,7,0,0}; frame_err pulses exactly once.
- Send 4 beats 9,10,11,12 with s_last=0 throughout -> frame {9,10,11,12}; frame_err pulses once.
- Continuous stream with m_ready=1 for 3 frames -> no s_ready deassertion; m_valid high for one cycle per frame, 4 cycles apart.
- Assert rst_n=0 after 2 beats, then send 1..4 -> output {1,2,3,4}, with no residue from the partial frame. With FEATURE_FRAME_BUF_FLUSH_EN defined, flush after 2 beats gives the same result.
